keypad_input: RTL and testbench
===============================

// Module: keypad_input
// PURPOSE
// - Conditions raw player switches into the 16-key CHIP-8 keypad_matrix consumed by cpu (today tied to 0).
// - Synchronises, debounces and exposes a stable matrix plus a wait-for-key handshake (FX0A).
// - Sits between top-level switches_p1/switches_p2 and cpu.keypad_matrix.
// PARAMETERS
// - TICK_DIV     256  clk cycles per debounce sample tick (>=2)
// - DEBOUNCE_N   4    consecutive differing samples required to flip a key (>=1)
// PORTS
// - clk             in   1   system clock; only clock
// - reset           in   1   synchronous, active-high reset
// - switches_p1     in   8   raw keys 0..7, asynchronous, 1 = pressed
// - switches_p2     in   8   raw keys 8..15, asynchronous, 1 = pressed
// - keypad_matrix   out  16  debounced state, bit i = key i held
// - key_press       out  16  one-cycle pulse per key on debounced 0->1
// - wait_req        in   1   level from cpu: FX0A in progress
// - wait_ack        out  1   one-cycle pulse: key captured, wait_key valid this cycle
// - wait_key        out  4   captured key index; holds until next ack
// BEHAVIOUR
// - Reset: all outputs 0; sync flops, prescaler, debounce counters, stable state 0; FSM IDLE.
// - raw = {switches_p2, switches_p1}; two-flop synchroniser per bit -> sync[15:0].
// - Prescaler counts 0..TICK_DIV-1, wraps to 0; tick = 1 for the cycle count == TICK_DIV-1.
// - Per key, on tick only: sync==stable -> cnt<=0; else if cnt==DEBOUNCE_N-1 -> stable<=~stable,
//   cnt<=0; else cnt<=cnt+1. Any agreeing sample restarts the count (glitch rejection).
// - cnt width $clog2(DEBOUNCE_N)+1; never exceeds DEBOUNCE_N-1.
// - keypad_matrix = stable (registered). key_press[i] = stable rose last cycle; multiple bits may pulse together.
// - Latency raw edge -> keypad_matrix: 2 sync cycles + DEBOUNCE_N ticks (+ up to TICK_DIV-1 phase).
// - Wait FSM (IDLE, ARMED, HELD):
//   IDLE : wait_req=1 -> mask<=stable (keys held at entry ignored) -> ARMED.
//   ARMED: mask<=mask & stable each cycle (released keys become eligible);
//          any key_press[i] & ~mask[i] -> latch lowest such i -> HELD.
//   HELD : stable[latched]==0 -> wait_ack=1, wait_key<=latched, -> IDLE.
//   wait_req=0 in ARMED/HELD -> IDLE, no ack, wait_key unchanged.
//   Ack and wait_req high in same cycle: next cycle re-arms as from IDLE (cpu must drop req).
// - Simultaneous press of several eligible keys: lowest index wins; others ignored.
// - Reset mid-wait or mid-debounce: immediate return to reset state, no ack.
// - All arithmetic unsigned; prescaler width $clog2(TICK_DIV).
// STRUCTURE
// - ghostchip_pkg: KEY_COUNT=16, KEY_IDX_W=4, typedef wait_state_t {IDLE, ARMED, HELD}.
// - Sub-module key_debounce (sync + counter + stable, one key, DEBOUNCE_N param), generate x16.
// - Prescaler, press detect, priority encoder, wait FSM stay in keypad_input.
// TESTING (bench: TICK_DIV=4, DEBOUNCE_N=3)
// - Reset, hold switches_p1=8'h01 -> keypad_matrix=16'h0001 after 2 + 3 ticks, key_press[0] one cycle.
// - Key 5 glitch high 2 ticks then low -> keypad_matrix stays 0, no key_press.
// - switches_p2=8'h80 released -> bit 15 clears after 3 ticks, no key_press pulse.
// - Hold key 3, raise wait_req, press+release key 9 -> wait_ack one cycle, wait_key=4'h9; key 3 ignored.
// - Press keys 2 and 7 same cycle in ARMED, release both -> wait_key=4'h2.
// - Drop wait_req while HELD, or assert reset mid-debounce -> no wait_ack; all outputs 0 after reset.

Source files
------------

// File: rtl/ghostchip_pkg.sv
// ghostchip_pkg: shared keypad constants, wait FSM states and lowest-index key encoder
package ghostchip_pkg;
  localparam int KEY_COUNT = 16;
  localparam int KEY_IDX_W = 4;
  typedef enum logic [1:0] {IDLE, ARMED, HELD} wait_state_t;
  function automatic logic [KEY_IDX_W-1:0] lowest_key(input logic [KEY_COUNT-1:0] v);
    lowest_key = '0;
    for (int i = KEY_COUNT - 1; i >= 0; i--)
      if (v[i]) lowest_key = KEY_IDX_W'(i);
  endfunction
endpackage

// File: rtl/key_debounce.sv
// key_debounce: two-flop synchroniser plus tick-sampled debounce counter for one key
module key_debounce import ghostchip_pkg::*; #(
  parameter int DEBOUNCE_N = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  input  logic tick,
  output logic stable
);
  localparam int CW = $clog2(DEBOUNCE_N) + 1;
  logic sync1_q, sync1_d, sync2_q, sync2_d, stable_q, stable_d, flip;
  logic [CW-1:0] cnt_q, cnt_d;
  always_comb begin
    sync1_d = raw;
    sync2_d = sync1_q;
    flip = tick && (sync2_q != stable_q) && (cnt_q == CW'(DEBOUNCE_N - 1));
    stable_d = flip ? ~stable_q : stable_q;
    cnt_d = !tick ? cnt_q : (sync2_q == stable_q || flip) ? '0 : cnt_q + 1'b1;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      stable_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      stable_q <= stable_d;
      cnt_q <= cnt_d;
    end
  end
  assign stable = stable_q;
endmodule

// File: rtl/keypad_input.sv
// keypad_input: debounced 16-key keypad matrix, press pulses and FX0A wait-for-key handshake
module keypad_input import ghostchip_pkg::*; #(
  parameter int TICK_DIV = 256,
  parameter int DEBOUNCE_N = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [7:0]           switches_p1,
  input  logic [7:0]           switches_p2,
  output logic [KEY_COUNT-1:0] keypad_matrix,
  output logic [KEY_COUNT-1:0] key_press,
  input  logic                 wait_req,
  output logic                 wait_ack,
  output logic [KEY_IDX_W-1:0] wait_key
);
  localparam int PW = $clog2(TICK_DIV);
  logic [PW-1:0] pre_q, pre_d;
  logic tick, ack_q, ack_d;
  logic [KEY_COUNT-1:0] raw, stable, prev_q, prev_d, mask_q, mask_d, elig;
  logic [KEY_IDX_W-1:0] latched_q, latched_d, wait_key_q, wait_key_d;
  wait_state_t state_q, state_d;
  assign raw = {switches_p2, switches_p1};
  for (genvar k = 0; k < KEY_COUNT; k++) begin : g_key
    key_debounce #(.DEBOUNCE_N(DEBOUNCE_N)) u_db (
      .clk    (clk),
      .reset  (reset),
      .raw    (raw[k]),
      .tick   (tick),
      .stable (stable[k])
    );
  end
  always_comb begin
    tick = pre_q == PW'(TICK_DIV - 1);
    pre_d = tick ? '0 : pre_q + 1'b1;
    prev_d = stable;
    elig = key_press & ~mask_q;
    state_d = state_q;
    mask_d = mask_q;
    latched_d = latched_q;
    wait_key_d = wait_key_q;
    ack_d = 1'b0;
    if (state_q == IDLE) begin
      mask_d = stable;
      state_d = wait_req ? ARMED : IDLE;
    end else if (!wait_req) begin
      state_d = IDLE;
    end else if (state_q == ARMED) begin
      mask_d = mask_q & stable;
      latched_d = |elig ? lowest_key(elig) : latched_q;
      state_d = |elig ? HELD : ARMED;
    end else if (!stable[latched_q]) begin
      ack_d = 1'b1;
      wait_key_d = latched_q;
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      pre_q <= '0;
      prev_q <= '0;
      mask_q <= '0;
      latched_q <= '0;
      wait_key_q <= '0;
      ack_q <= 1'b0;
      state_q <= IDLE;
    end else begin
      pre_q <= pre_d;
      prev_q <= prev_d;
      mask_q <= mask_d;
      latched_q <= latched_d;
      wait_key_q <= wait_key_d;
      ack_q <= ack_d;
      state_q <= state_d;
    end
  end
  assign keypad_matrix = stable;
  assign key_press = stable & ~prev_q;
  assign wait_ack = ack_q;
  assign wait_key = wait_key_q;
endmodule

// File: tb/tb_keypad_input.sv
// tb_keypad_input: directed and randomized checks of keypad_input against a sample-history model
module tb_keypad_input;
  localparam int TD = 4;
  localparam int DN = 3;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [7:0] sw1 = '0;
  logic [7:0] sw2 = '0;
  logic wait_req = 1'b0;
  logic [15:0] keypad_matrix, key_press;
  logic wait_ack;
  logic [3:0] wait_key;
  int tests = 0;
  int fails = 0;
  logic [15:0] m_s1, m_s2, m_st, m_prev;
  int m_run [16];
  int m_pre;
  always #5 clk = ~clk;
  keypad_input #(.TICK_DIV(TD), .DEBOUNCE_N(DN)) dut (
    .clk           (clk),
    .reset         (reset),
    .switches_p1   (sw1),
    .switches_p2   (sw2),
    .keypad_matrix (keypad_matrix),
    .key_press     (key_press),
    .wait_req      (wait_req),
    .wait_ack      (wait_ack),
    .wait_key      (wait_key)
  );
  // A key flips once DN consecutive tick samples of the 2-cycle-delayed raw disagree with it.
  always @(posedge clk) begin
    if (reset) begin
      m_s1 = '0; m_s2 = '0; m_st = '0; m_prev = '0; m_pre = 0;
      for (int i = 0; i < 16; i++) m_run[i] = 0;
    end else begin
      m_prev = m_st;
      if (m_pre == TD - 1)
        for (int i = 0; i < 16; i++) begin
          m_run[i] = (m_s2[i] != m_st[i]) ? m_run[i] + 1 : 0;
          if (m_run[i] == DN) begin m_st[i] = ~m_st[i]; m_run[i] = 0; end
        end
      m_s2 = m_s1;
      m_s1 = {sw2, sw1};
      m_pre = (m_pre + 1) % TD;
    end
  end
  task automatic settle(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic test_reset;
    reset = 1'b1;
    settle(3);
    tests++; if (keypad_matrix !== 16'h0) begin fails++; $display("FAIL reset_matrix got %h want 0000", keypad_matrix); end
    tests++; if (key_press !== 16'h0) begin fails++; $display("FAIL reset_press got %h want 0000", key_press); end
    tests++; if (wait_ack !== 1'b0) begin fails++; $display("FAIL reset_ack got %b want 0", wait_ack); end
    tests++; if (wait_key !== 4'h0) begin fails++; $display("FAIL reset_key got %h want 0", wait_key); end
    reset = 1'b0;
  endtask
  task automatic test_single_press;
    int pulses = 0;
    int first = -1;
    sw1 = 8'h01;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      tests++;
      if (keypad_matrix !== m_st || key_press !== (m_st & ~m_prev)) begin
        fails++; $display("FAIL press_model c=%0d got %h/%h want %h/%h", c, keypad_matrix, key_press, m_st, m_st & ~m_prev);
      end
      if (key_press[0]) pulses++;
      if (keypad_matrix[0] && first < 0) first = c;
    end
    tests++; if (keypad_matrix !== 16'h0001) begin fails++; $display("FAIL press_matrix got %h want 0001", keypad_matrix); end
    tests++; if (pulses !== 1) begin fails++; $display("FAIL press_pulses got %0d want 1", pulses); end
    tests++; if (first < 10 || first > 13) begin fails++; $display("FAIL press_latency got %0d want 10..13", first); end
    sw1 = 8'h00;
    settle(30);
  endtask
  task automatic test_glitch;
    logic seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      sw1 = (c < 8) ? 8'h20 : 8'h00;
      @(negedge clk);
      tests++;
      if (keypad_matrix !== m_st || key_press !== (m_st & ~m_prev)) begin
        fails++; $display("FAIL glitch_model c=%0d got %h/%h want %h/%h", c, keypad_matrix, key_press, m_st, m_st & ~m_prev);
      end
      seen |= keypad_matrix[5] | key_press[5];
    end
    sw1 = 8'h00;
    tests++; if (seen !== 1'b0) begin fails++; $display("FAIL glitch_key5 got %b want 0", seen); end
  endtask
  task automatic test_release;
    int pulses = 0;
    sw2 = 8'h80;
    settle(30);
    tests++; if (keypad_matrix !== 16'h8000) begin fails++; $display("FAIL release_held got %h want 8000", keypad_matrix); end
    sw2 = 8'h00;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (|key_press) pulses++;
    end
    tests++; if (keypad_matrix !== 16'h0000) begin fails++; $display("FAIL release_matrix got %h want 0000", keypad_matrix); end
    tests++; if (pulses !== 0) begin fails++; $display("FAIL release_pulses got %0d want 0", pulses); end
  endtask
  task automatic test_wait_key9;
    int acks = 0;
    logic [3:0] k = 4'hf;
    sw1 = 8'h08;
    settle(30);
    wait_req = 1'b1;
    for (int c = 0; c < 100; c++) begin
      sw2 = (c >= 5 && c < 35) ? 8'h02 : 8'h00;
      @(negedge clk);
      if (wait_ack) begin acks++; k = wait_key; end
      if (acks == 1 && wait_ack) wait_req = 1'b0;
    end
    wait_req = 1'b0;
    tests++; if (acks !== 1) begin fails++; $display("FAIL wait9_acks got %0d want 1", acks); end
    tests++; if (k !== 4'h9) begin fails++; $display("FAIL wait9_key got %h want 9", k); end
    tests++; if (wait_key !== 4'h9) begin fails++; $display("FAIL wait9_hold got %h want 9", wait_key); end
    sw1 = 8'h00;
    settle(30);
  endtask
  task automatic test_simultaneous;
    int acks = 0;
    logic [3:0] k = 4'hf;
    wait_req = 1'b1;
    for (int c = 0; c < 100; c++) begin
      sw1 = (c >= 3 && c < 33) ? 8'h84 : 8'h00;
      @(negedge clk);
      if (wait_ack) begin acks++; k = wait_key; wait_req = 1'b0; end
    end
    wait_req = 1'b0;
    tests++; if (acks !== 1) begin fails++; $display("FAIL simul_acks got %0d want 1", acks); end
    tests++; if (k !== 4'h2) begin fails++; $display("FAIL simul_key got %h want 2", k); end
  endtask
  task automatic test_drop_held;
    int acks = 0;
    wait_req = 1'b1;
    sw1 = 8'h10;
    settle(30);
    wait_req = 1'b0;
    for (int c = 0; c < 60; c++) begin
      if (c == 5) sw1 = 8'h00;
      @(negedge clk);
      if (wait_ack) acks++;
    end
    tests++; if (acks !== 0) begin fails++; $display("FAIL drop_acks got %0d want 0", acks); end
    tests++; if (wait_key !== 4'h2) begin fails++; $display("FAIL drop_key got %h want 2", wait_key); end
  endtask
  task automatic test_reset_mid;
    int acks = 0;
    wait_req = 1'b1;
    sw1 = 8'h02;
    settle(8);
    reset = 1'b1;
    sw1 = 8'h00;
    settle(2);
    tests++; if ({keypad_matrix, key_press, wait_ack, wait_key} !== 37'h0) begin
      fails++; $display("FAIL rstmid_outputs got %h/%h/%b/%h want 0", keypad_matrix, key_press, wait_ack, wait_key);
    end
    reset = 1'b0;
    wait_req = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (wait_ack) acks++;
    end
    tests++; if (acks !== 0) begin fails++; $display("FAIL rstmid_acks got %0d want 0", acks); end
    tests++; if (keypad_matrix !== 16'h0) begin fails++; $display("FAIL rstmid_matrix got %h want 0000", keypad_matrix); end
  endtask
  task automatic test_random;
    for (int s = 0; s < 60; s++) begin
      int len = int'($urandom_range(1, 24));
      sw1 = 8'($urandom);
      sw2 = 8'($urandom);
      for (int c = 0; c < len; c++) begin
        @(negedge clk);
        tests++;
        if (keypad_matrix !== m_st || key_press !== (m_st & ~m_prev)) begin
          fails++; $display("FAIL random_model s=%0d got %h/%h want %h/%h", s, keypad_matrix, key_press, m_st, m_st & ~m_prev);
        end
      end
    end
    sw1 = 8'h00;
    sw2 = 8'h00;
    settle(30);
  endtask
  initial begin
    test_reset();
    test_single_press();
    test_glitch();
    test_release();
    test_wait_key9();
    test_simultaneous();
    test_drop_held();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
